// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multicycle MIPS control FSM. Sequences fetch, decode, execute,
//               memory and writeback. Drives the ALU opcode, operand muxes,
//               memory strobes and register/PC write enables. Uses the ALU
//               zero flag to decide beq.
// Ports       : clk, reset (sync, active-high)
//               opcode[5:0], funct[5:0], zero, mem_ready         (inputs)
//               alu_control[3:0], alu_src_a, alu_src_b[1:0], iord,
//               mem_read, mem_write, ir_write, reg_write, reg_dst,
//               mem_to_reg, pc_write, pc_source[1:0], illegal_instr,
//               state[3:0]                                        (outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam state_t C_RESET_S = state_t'(RESET_STATE);

  localparam logic [3:0] C_ALU_AND  = 4'b0000;
  localparam logic [3:0] C_ALU_OR   = 4'b0001;
  localparam logic [3:0] C_ALU_ADD  = 4'b0010;
  localparam logic [3:0] C_ALU_SUB  = 4'b0110;
  localparam logic [3:0] C_ALU_SLT  = 4'b0111;
  localparam logic [3:0] C_ALU_SLTU = 4'b1000;
  localparam logic [3:0] C_ALU_SLL  = 4'b1001;
  localparam logic [3:0] C_ALU_SRL  = 4'b1010;

  state_t state_q, state_d;

  // R-type funct decode: ALU operation plus a legality flag.
  logic [3:0] funct_alu;
  logic       funct_ok;

  always_comb begin
    funct_alu = C_ALU_ADD;
    funct_ok  = 1'b1;
    case (funct)
      6'h20, 6'h21: funct_alu = C_ALU_ADD;
      6'h22, 6'h23: funct_alu = C_ALU_SUB;
      6'h24:        funct_alu = C_ALU_AND;
      6'h25:        funct_alu = C_ALU_OR;
      6'h2A:        funct_alu = C_ALU_SLT;
      6'h2B:        funct_alu = C_ALU_SLTU;
      6'h00:        funct_alu = C_ALU_SLL;
      6'h02:        funct_alu = C_ALU_SRL;
      default:      funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= C_RESET_S;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    alu_control   = C_ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    pc_write      = 1'b0;
    pc_source     = 2'b00;
    illegal_instr = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC+4 are only committed on the cycle memory delivers.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        alu_src_b = 2'b11;
        case (opcode)
          6'h00: begin
            if (funct_ok) state_d = S_EXEC;
            else          illegal_instr = 1'b1;
          end
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h04:        state_d = S_BRANCH;
          6'h08:        state_d = S_ADDIEX;
          6'h02:        state_d = S_JUMP;
          default:      illegal_instr = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = C_ALU_SUB;
        pc_source   = 2'b01;
        pc_write    = zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset abandons any instruction in flight: no side effects this cycle.
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      pc_write  = 1'b0;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire
